// File: rtl/prog_seq_pkg.sv
// Shared types and program tables for the program sequencer.
// START_TBL/END_TBL give each program's first and last PC.
package prog_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    FINISH
  } state_t;

  localparam int AW = 16;

  localparam logic [15:0] DEF_TIMEOUT = 16'd4000;

  localparam logic [15:0] START_TBL [3] = '{
    16'd0, 16'd124, 16'd301
  };

  localparam logic [15:0] END_TBL [3] = '{
    16'd123, 16'd300, 16'd511
  };

endpackage

// File: rtl/prog_cycle_ctr.sv
// Saturating RUN-cycle counter with synchronous clear and a
// terminal-count flag raised when the count sits at TIMEOUT-1.
module prog_cycle_ctr #(
  parameter int          AW      = 16,
  parameter logic [15:0] TIMEOUT = 16'd4000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [AW-1:0] count,
  output logic          tc
);

  localparam logic [AW-1:0] TC_VAL = AW'(TIMEOUT - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + AW'(1);
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/prog_sequencer.sv
// Runs a fixed list of programs one after another, holding the
// fetch unit in reset between runs and ending each on PC or watchdog.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int          NUM_PROGS = 3,
  parameter logic [15:0] TIMEOUT   = prog_seq_pkg::DEF_TIMEOUT,
  parameter int          AW        = prog_seq_pkg::AW
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          Start,
  input  logic [AW-1:0] PC,
  output logic          Init,
  output logic [AW-1:0] Start_addr,
  output logic [1:0]    Prog_idx,
  output logic          Done,
  output logic          Timeout,
  output logic [AW-1:0] Cycles
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_PROGS - 1);

  state_t        state;
  logic [AW-1:0] end_addr;
  logic          end_match;
  logic          tc;
  logic          clr;
  logic          en;

  always_comb begin
    Start_addr = '0;
    end_addr   = '1;
    case (Prog_idx)
      2'd0: begin
        Start_addr = AW'(START_TBL[0]);
        end_addr   = AW'(END_TBL[0]);
      end
      2'd1: begin
        Start_addr = AW'(START_TBL[1]);
        end_addr   = AW'(END_TBL[1]);
      end
      2'd2: begin
        Start_addr = AW'(START_TBL[2]);
        end_addr   = AW'(END_TBL[2]);
      end
      default: ;
    endcase
  end

  assign end_match = (PC == end_addr);

  // Clear on entry to LOAD so Cycles already reads 0 during LOAD
  assign clr = ((state == IDLE) && Start) || (state == LOAD);
  assign en  = (state == RUN) && !end_match;

  prog_cycle_ctr #(
    .AW      (AW),
    .TIMEOUT (TIMEOUT)
  ) u_ctr (
    .clk   (CLK),
    .rst   (Reset),
    .clr   (clr),
    .en    (en),
    .count (Cycles),
    .tc    (tc)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      Prog_idx <= '0;
      Init     <= 1'b1;
      Done     <= 1'b0;
      Timeout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            state   <= LOAD;
            Timeout <= 1'b0;
          end
        end
        LOAD: begin
          state <= RUN;
          Init  <= 1'b0;
        end
        RUN: begin
          if (end_match) begin
            state   <= FINISH;
            Init    <= 1'b1;
            Done    <= 1'b1;
            Timeout <= 1'b0;
          end else if (tc) begin
            state   <= FINISH;
            Init    <= 1'b1;
            Done    <= 1'b1;
            Timeout <= 1'b1;
          end
        end
        FINISH: begin
          if (!Start) begin
            state    <= IDLE;
            Done     <= 1'b0;
            Prog_idx <= (Prog_idx == LAST_IDX) ?
                        2'd0 : Prog_idx + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
